// File: rtl/tlv5618_pkg.sv
// ---------------------------------------------------------------------------
// tlv5618_pkg : command-word layout, R1R0 codes and FSM states for tlv5618_ctrl
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tlv5618_pkg;

  localparam int BIT_R1   = 15;
  localparam int BIT_SPD  = 14;
  localparam int BIT_PWR  = 13;
  localparam int BIT_R0   = 12;
  localparam int BIT_DMSB = 11;

  localparam logic [1:0] CMD_BUF   = 2'b01;
  localparam logic [1:0] CMD_A_UPD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_B = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_SEND_A = 3'd3,
    ST_WAIT_A = 3'd4
  } state_e;

  function automatic logic [15:0] build_cmd(input logic [1:0]  cmd,
                                            input logic        spd,
                                            input logic        pwr,
                                            input logic [11:0] data);
    logic [15:0] w;
    w              = '0;
    w[BIT_R1]      = cmd[1];
    w[BIT_SPD]     = spd;
    w[BIT_PWR]     = pwr;
    w[BIT_R0]      = cmd[0];
    w[BIT_DMSB:0]  = data;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlv5618_ctrl.sv
// ---------------------------------------------------------------------------
// tlv5618_ctrl : sequences a channel pair into buffer-B then A+update commands
//                for tlv5618_driver. Optional macro: TLV5618_AUTO_REFRESH_EN.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tlv5618_ctrl
  import tlv5618_pkg::*;
#(
  parameter bit          SPD_FAST       = 1'b1,
  parameter int unsigned REFRESH_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] ch_a,
  input  logic [11:0] ch_b,
  input  logic        pwr_down,
  output logic [15:0] DAC_data,
  output logic        set_go,
  input  logic        set_done,
  output logic        busy,
  output logic [15:0] upd_cnt
);

  state_e      state_q, state_d;
  logic [11:0] a_q, a_d;
  logic [11:0] b_q, b_d;
  logic        pwr_q, pwr_d;
  logic [15:0] dac_q, dac_d;
  logic        go_q, go_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic        refresh_due;

`ifdef TLV5618_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES);

  logic [RW-1:0] rf_q, rf_d;

  assign refresh_due = (state_q == ST_IDLE) && (rf_q == RW'(REFRESH_CYCLES - 1));

  // Counts only while idling; any departure from IDLE restarts the period.
  always_comb begin
    rf_d = '0;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
      rf_d = rf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = (REFRESH_CYCLES >= 2);
  assign refresh_due = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pwr_d   = pwr_q;
    dac_d   = dac_q;
    go_d    = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          a_d     = ch_a;
          b_d     = ch_b;
          pwr_d   = pwr_down;
          state_d = ST_SEND_B;
        end else if (refresh_due) begin
          state_d = ST_SEND_B;
        end
      end
      ST_SEND_B: state_d = ST_WAIT_B;
      ST_WAIT_B: if (set_done) state_d = ST_SEND_A;
      ST_SEND_A: state_d = ST_WAIT_A;
      ST_WAIT_A: begin
        if (set_done) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so the word and go pulse
    // appear together in the SEND_x cycle and stay put through WAIT_x.
    if (state_d == ST_SEND_B) begin
      dac_d = build_cmd(CMD_BUF, SPD_FAST, pwr_d, b_d);
      go_d  = 1'b1;
    end else if (state_d == ST_SEND_A) begin
      dac_d = build_cmd(CMD_A_UPD, SPD_FAST, pwr_d, a_d);
      go_d  = 1'b1;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      pwr_q   <= 1'b0;
      dac_q   <= '0;
      go_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pwr_q   <= pwr_d;
      dac_q   <= dac_d;
      go_q    <= go_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign set_go   = go_q;
  assign DAC_data = dac_q;
  assign upd_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tlv5618_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlv5618_ctrl : scoreboard bench for tlv5618_ctrl with a set_done driver model
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tlv5618_ctrl;

  localparam int DLY = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, pwr_down, set_go, set_done, busy;
  logic [11:0] ch_a, ch_b;
  logic [15:0] DAC_data, upd_cnt;
  logic        drv_done, spur_done;
  int          drv_left;

  always #5 clk = ~clk;

  assign set_done = drv_done | spur_done;

  tlv5618_ctrl #(.SPD_FAST(1'b1), .REFRESH_CYCLES(50_000)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ch_a     (ch_a),
    .ch_b     (ch_b),
    .pwr_down (pwr_down),
    .DAC_data (DAC_data),
    .set_go   (set_go),
    .set_done (set_done),
    .busy     (busy),
    .upd_cnt  (upd_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp;
  bit          pending = 0;
  bit          go_next = 0;
  logic [15:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver model: completes each transaction DLY cycles after its set_go.
  initial begin
    drv_done = 1'b0;
    drv_left = 0;
    forever begin
      @(posedge clk);
      #2;
      drv_done = 1'b0;
      if (!rst_n) begin
        drv_left = 0;
      end else if (set_go) begin
        drv_left = DLY;
      end else if (drv_left > 0) begin
        drv_left--;
        if (drv_left == 0) drv_done = 1'b1;
      end
    end
  end

  // Monitor: pops the expected word on every set_go.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      go_next = 0;
    end else begin
      if (go_next) begin
        check("go_after_done", {31'd0, set_go}, 32'd1);
        go_next = 0;
      end
      if (set_go) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_go: got set_go with word 0x%h, expected none", DAC_data);
        end else begin
          cur_exp = exp_q.pop_front();
          pending = 1;
          check("word", {16'd0, DAC_data}, {16'd0, cur_exp});
        end
      end else if (set_done && pending) begin
        check("word_hold", {16'd0, DAC_data}, {16'd0, cur_exp});
        pending = 0;
        if (exp_q.size() > 0) go_next = 1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_go"},    {31'd0, set_go},   32'd0);
    check({tag, "_dac"},   {16'd0, DAC_data}, 32'd0);
    check({tag, "_cnt"},   {16'd0, upd_cnt},  32'd0);
  endtask

  task automatic send_pair(input logic [11:0] a, input logic [11:0] b, input logic pd,
                           input logic [15:0] w1, input logic [15:0] w2, input int hold);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got in_ready 0, expected 1");
    end
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    ch_a     = a;
    ch_b     = b;
    pwr_down = pd;
    in_valid = 1'b1;
    @(negedge clk);
    check("accept_go", {31'd0, set_go}, 32'd1);
    check("accept_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      ch_a     = ~ch_a;
      ch_b     = ch_b + 12'h111;
      pwr_down = ~pwr_down;
      @(negedge clk);
      check("ready_hold", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_seq_end();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && set_done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL seq_timeout: got no final set_done, expected one within 200 cycles");
    end
    @(negedge clk);
    exp_cnt++;
    check("ready_back", {31'd0, in_ready}, 32'd1);
    check("busy_clr",   {31'd0, busy},     32'd0);
    check("upd_cnt",    {16'd0, upd_cnt},  {16'd0, exp_cnt});
  endtask

`ifdef TLV5618_AUTO_REFRESH_EN
  logic        rf_valid, rf_ready, rf_go, rf_done, rf_busy, rf_pwr;
  logic [11:0] rf_a, rf_b;
  logic [15:0] rf_dac, rf_cnt;
  int          rf_left;

  tlv5618_ctrl #(.SPD_FAST(1'b1), .REFRESH_CYCLES(20)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rf_valid),
    .in_ready (rf_ready),
    .ch_a     (rf_a),
    .ch_b     (rf_b),
    .pwr_down (rf_pwr),
    .DAC_data (rf_dac),
    .set_go   (rf_go),
    .set_done (rf_done),
    .busy     (rf_busy),
    .upd_cnt  (rf_cnt)
  );

  initial begin
    rf_done = 1'b0;
    rf_left = 0;
    forever begin
      @(posedge clk);
      #2;
      rf_done = 1'b0;
      if (!rst_n) begin
        rf_left = 0;
      end else if (rf_go) begin
        rf_left = DLY;
      end else if (rf_left > 0) begin
        rf_left--;
        if (rf_left == 0) rf_done = 1'b1;
      end
    end
  end

  task automatic rf_wait_go(input string name, input logic [15:0] w, output int waited);
    waited = 0;
    while (!rf_go && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!rf_go) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no set_go, expected word 0x%h", name, w);
    end else begin
      check(name, {16'd0, rf_dac}, {16'd0, w});
    end
    @(negedge clk);
  endtask

  task automatic rf_wait_ready(input logic [15:0] cnt);
    int t;
    t = 0;
    while (!rf_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rf_ready", {31'd0, rf_ready}, 32'd1);
    check("rf_upd_cnt", {16'd0, rf_cnt}, {16'd0, cnt});
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef TLV5618_AUTO_REFRESH_EN
    int wt;
    rf_valid = 1'b0;
    rf_a     = '0;
    rf_b     = '0;
    rf_pwr   = 1'b0;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ch_a      = '0;
    ch_b      = '0;
    pwr_down  = 1'b0;
    spur_done = 1'b0;
    exp_cnt   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    send_pair(12'h800, 12'h123, 1'b0, 16'h5123, 16'hC800, 0);
    wait_seq_end();

    send_pair(12'hFFF, 12'h000, 1'b1, 16'h7000, 16'hEFFF, 0);
    wait_seq_end();

    // Inputs churn while in_valid stays high through WAIT_B.
    send_pair(12'hABC, 12'h456, 1'b0, 16'h5456, 16'hCABC, 4);
    wait_seq_end();

    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_ready", {31'd0, in_ready}, 32'd1);
    check("spur_busy",  {31'd0, busy},     32'd0);
    check("spur_go",    {31'd0, set_go},   32'd0);
    check("spur_cnt",   {16'd0, upd_cnt},  {16'd0, exp_cnt});

    // Reset while the A+update transaction is outstanding.
    send_pair(12'h0F0, 12'h00F, 1'b0, 16'h500F, 16'hC0F0, 0);
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pair(12'h7FF, 12'h001, 1'b0, 16'h5001, 16'hC7FF, 0);
    wait_seq_end();

`ifdef TLV5618_AUTO_REFRESH_EN
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    rst_n    = 1'b1;
    rf_a     = 12'h321;
    rf_b     = 12'h654;
    rf_pwr   = 1'b0;
    rf_valid = 1'b1;
    @(negedge clk);
    rf_valid = 1'b0;
    rf_wait_go("rf_w1", 16'h5654, wt);
    rf_wait_go("rf_w2", 16'hC321, wt);
    rf_wait_ready(16'd1);
    rf_wait_go("rf_refresh_w1", 16'h5654, wt);
    check("rf_refresh_period", wt, 32'd20);
    rf_wait_go("rf_refresh_w2", 16'hC321, wt);
    rf_wait_ready(16'd2);
    // New pair arrives exactly on the expiry cycle and must win.
    repeat (19) @(negedge clk);
    rf_a     = 12'h111;
    rf_b     = 12'h222;
    rf_pwr   = 1'b1;
    rf_valid = 1'b1;
    @(negedge clk);
    rf_valid = 1'b0;
    rf_wait_go("rf_new_w1", 16'h7222, wt);
    rf_wait_go("rf_new_w2", 16'hE111, wt);
    rf_wait_ready(16'd3);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
